// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM subsystem: RAM status, arbiter grant
// states and the default dcache run length before an ifetch may preempt.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arbstate_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache. The dcache has priority
// and keeps the grant across back-to-back words; a pending ifetch takes the
// port at the end of a two-word block once the dcache has completed
// STARVE_LIMIT words in a row. RAM status ERROR is treated as not-done and
// recorded in a sticky flag.
//
// Handshake: a requester holds its request (iREN / dREN / dWEN) together
// with address and store data stable until it sees its wait output low at
// a rising edge; that edge completes exactly one word. Dropping the request
// before then abandons the word and releases the grant at the next edge.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int WORD_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // icache side
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // status
  output logic              ramerr,
  output logic [1:0]        arbstate
);

  arbstate_t  state_q, state_n;
  logic [2:0] dcnt_q;
  logic [2:0] dcnt_inc;
  logic       ramerr_q;
  logic       dreq;
  logic       done;
  logic       rs_error;
  logic       preempt;

  assign dreq     = dREN | dWEN;
  assign done     = (ramstate_t'(ramstate) == ACCESS);
  assign rs_error = (ramstate_t'(ramstate) == ERROR);

  // Saturating count of dcache words, including the one completing now.
  assign dcnt_inc = (dcnt_q == 3'd7) ? 3'd7 : dcnt_q + 3'd1;

  // Ifetch takes over only when the odd word of a block completes.
  assign preempt = done & daddr[2] & iREN & (int'(dcnt_inc) >= STARVE_LIMIT);

  // Next-state selection; dcache wins simultaneous requests from IDLE.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (dreq)      state_n = DGNT;
        else if (iREN) state_n = IGNT;
      end
      DGNT: begin
        if (!dreq)        state_n = iREN ? IGNT : IDLE;
        else if (preempt) state_n = IGNT;
      end
      IGNT: begin
        if (!iREN)             state_n = dreq ? DGNT : IDLE;
        else if (done && dreq) state_n = DGNT;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Dcache run-length counter: cleared while idle and on every ifetch grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dcnt_q <= 3'd0;
    end else if (state_q == IDLE || (state_n == IGNT && state_q != IGNT)) begin
      dcnt_q <= 3'd0;
    end else if (state_q == DGNT && done) begin
      dcnt_q <= dcnt_inc;
    end
  end

  // Sticky RAM error flag, only meaningful while someone holds the port.
  always_ff @(posedge CLK) begin
    if (RST)                              ramerr_q <= 1'b0;
    else if (state_q != IDLE && rs_error) ramerr_q <= 1'b1;
  end

  // Port routing decoded from the grant; reset forces the idle view at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    if (!RST) begin
      unique case (state_q)
        DGNT: begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          dwait    = ~done;
        end
        IGNT: begin
          ramaddr = iaddr;
          ramREN  = iREN;
          iwait   = ~done;
        end
        default: begin
        end
      endcase
    end
  end

  assign iload    = ramload;
  assign dload    = ramload;
  assign ramerr   = ramerr_q;
  assign arbstate = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache. It grants the one RAM port to one requester at a time and routes address, store data and strobes. It holds the grant across a dcache two-word block burst and prevents instruction-fetch starvation with a bounded dcache run length. It sits between the cache pair and the RAM model, and takes the place of a purely combinational memory controller.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of completed dcache words after which a pending ifetch preempts the dcache at the next block boundary.
- `WORD_W`, default 32: data and address width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `CLK`  in  1  clock; all state updates on the rising edge.
  - `RST`  in  1  synchronous reset, active-high.
- Icache side:
  - `iREN`  in  1  icache read request.
  - `iaddr`  in  32  icache word address.
  - `iwait`  out  1  icache stall; low only in the cycle its word completes.
  - `iload`  out  32  read data, always equal to `ramload`.
- Dcache side:
  - `dREN`  in  1  dcache read request.
  - `dWEN`  in  1  dcache write request; wins over `dREN` if both are high.
  - `daddr`  in  32  dcache word address.
  - `dstore`  in  32  dcache write data.
  - `dwait`  out  1  dcache stall; low only in the cycle its word completes.
  - `dload`  out  32  read data, always equal to `ramload`.
- RAM side:
  - `ramREN`  out  1  RAM read strobe.
  - `ramWEN`  out  1  RAM write strobe.
  - `ramaddr`  out  32  RAM address.
  - `ramstore`  out  32  RAM write data.
  - `ramload`  in  32  RAM read data.
  - `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- Status:
  - `ramerr`  out  1  sticky; set on any cycle with `ramstate`==ERROR while a grant is active.

## Operation
Requests and grant:
- dreq = `dREN` | `dWEN`.
- done = (`ramstate`==ACCESS).
- Registered grant FSM with states IDLE, DGNT, IGNT. All outputs decode combinationally from the state.

Per-state outputs:
- IDLE: `ramREN`=`ramWEN`=0; `ramaddr`=`ramstore`=0; `iwait`=`dwait`=1.
- DGNT:
  - `ramaddr`=`daddr`, `ramstore`=`dstore`.
  - `ramWEN`=`dWEN`, `ramREN`=`dREN` & ~`dWEN`.
  - `dwait`=~done, `iwait`=1.
- IGNT:
  - `ramaddr`=`iaddr`, `ramREN`=`iREN`, `ramWEN`=0, `ramstore`=0.
  - `iwait`=~done, `dwait`=1.

Transitions:
- IDLE:
  - dreq → DGNT.
  - else `iREN` → IGNT.
  - else stay IDLE.
  - Dcache has priority on simultaneous requests.
- DGNT:
  - ~dreq → IGNT if `iREN`, else IDLE.
  - done & `daddr`[2]==1 & `iREN` & dcnt ≥ `STARVE_LIMIT` → IGNT, and clear dcnt (preemption at block end only).
  - Otherwise stay DGNT.
- IGNT:
  - ~`iREN` → DGNT if dreq, else IDLE.
  - done & dreq → DGNT.
  - Otherwise stay IGNT.

Starvation counter:
- dcnt is 3 bits wide and saturates at 7.
- Increments on done in DGNT.
- Clears on entry to IGNT and in IDLE.

ERROR handling:
- ERROR counts as not-done: the wait output stays high and the grant is held.
- `ramerr` is set and stays set until `RST`.

## Timing
- Reset:
  - `RST` high at an edge sets state=IDLE, dcnt=0, `ramerr`=0.
  - While `RST` is high, outputs are forced to the IDLE values combinationally, including in mid-burst cycles.
- Arbitration latency: one cycle. A request seen in IDLE reaches the RAM strobes in the next cycle.
- Word latency: the wait output falls in the first cycle with ACCESS under the grant.
- Burst hold:
  - Dcache back-to-back words with dreq continuously high and no preemption condition stay in DGNT.
  - No idle cycle between words.
- Handover:
  - The state switch takes effect at the edge after done.
  - The losing side sees wait=1 throughout.
- Requester drop: a request dropping mid-grant, with done never seen, releases the grant at the next edge and no RAM access is recorded.

## Structure
- `ramstate_t` (FREE/BUSY/ACCESS/ERROR) lives in `cpu_types_pkg`.
- `arbstate_t` (IDLE/DGNT/IGNT) lives in `cpu_types_pkg`.
- The `STARVE_LIMIT` default value lives in `cpu_types_pkg`.
- Single module. No sub-module is warranted: the FSM and counter are small.

## Test plan
- Reset mid-burst: assert `RST` in DGNT with `ramstate`=ACCESS → `ramWEN`=0 and `dwait`=1 immediately; IDLE and dcnt=0 after the edge.
- Priority: `iREN` and `dREN` rise together, `daddr`=0x100, ACCESS after 2 BUSY cycles → DGNT; `ramaddr`=0x100, `dwait` low in cycle 3, `iwait` stays 1.
- Burst hold: dcache writes 0x200 then 0x204 with `iREN` high, dcnt<4 → both words complete in DGNT with no IDLE cycle; IGNT after dreq drops.
- Starvation: dcache issues 6 continuous words 0x300..0x314 with `iREN` high and `STARVE_LIMIT`=4 → IGNT entered right after word 0x30C (fourth word, `daddr`[2]=1); `ramaddr`=`iaddr` next cycle.
- Both strobes: `dREN`=`dWEN`=1 → `ramWEN`=1, `ramREN`=0.
- Error: `ramstate`=ERROR for 3 cycles then ACCESS under IGNT → `iwait` high for 3 cycles then low; `ramerr`=1 and held until `RST`.
